// File: rtl/psw_context_unit.sv
// Exception entry / return sequencer: pushes PC and PSW, fetches the vector, or pops PSW and PC,
// then commits PSW, PC and SP in one cycle.
module psw_context_unit #(
  parameter logic [15:0] VECTOR_BASE = 16'hFFC0,
  parameter logic [15:0] EXC_PSW     = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] psw_in,
  input  logic [15:0] pc_in,
  input  logic [15:0] sp_in,
  input  logic        exc_req,
  input  logic [3:0]  exc_vector,
  input  logic        reti_req,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  psw_wr_en,
  output logic [15:0] psw_wr_data,
  output logic        pc_load,
  output logic [15:0] pc_out,
  output logic        sp_load,
  output logic [15:0] sp_out,
  output logic        busy,
  output logic        done
);

  localparam int unsigned W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH_PC, S_PUSH_PSW, S_FETCH_VEC, S_POP_PSW, S_POP_PC, S_COMMIT
  } state_e;

  typedef enum logic {M_EXC = 1'b0, M_RET = 1'b1} mode_e;

  state_e       state_q, state_d;
  mode_e        mode_q, mode_d;
  logic [W-1:0] pc_q, pc_d, psw_q, psw_d, sp_q, sp_d;
  logic [3:0]   vec_q, vec_d;

  logic         mem_req_q, mem_req_d, mem_wr_q, mem_wr_d;
  logic [W-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [1:0]   psw_wr_en_q, psw_wr_en_d;
  logic [W-1:0] psw_wr_data_q, psw_wr_data_d, pc_out_q, pc_out_d, sp_out_q, sp_out_d;
  logic         pc_load_q, pc_load_d, sp_load_q, sp_load_d, busy_q, busy_d, done_q, done_d;
  logic         ack;

  // Next state and captured context; outputs are decoded from the next state so they are flopped
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pc_d    = pc_q;
    psw_d   = psw_q;
    sp_d    = sp_q;
    vec_d   = vec_q;
    ack     = mem_req_q & mem_ack;

    case (state_q)
      S_IDLE: begin
        if (exc_req) begin
          pc_d    = pc_in;
          psw_d   = psw_in;
          sp_d    = sp_in;
          vec_d   = exc_vector;
          mode_d  = M_EXC;
          state_d = S_PUSH_PC;
        end else if (reti_req) begin
          sp_d    = sp_in;
          mode_d  = M_RET;
          state_d = S_POP_PSW;
        end
      end
      S_PUSH_PC:  if (ack) state_d = S_PUSH_PSW;
      S_PUSH_PSW: if (ack) state_d = S_FETCH_VEC;
      S_FETCH_VEC: if (ack) begin
        pc_d    = mem_rdata;
        state_d = S_COMMIT;
      end
      S_POP_PSW: if (ack) begin
        psw_d   = mem_rdata;
        state_d = S_POP_PC;
      end
      S_POP_PC: if (ack) begin
        pc_d    = mem_rdata;
        state_d = S_COMMIT;
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    mem_req_d     = 1'b0;
    mem_wr_d      = 1'b0;
    mem_addr_d    = '0;
    mem_wdata_d   = '0;
    psw_wr_en_d   = 2'b00;
    psw_wr_data_d = '0;
    pc_load_d     = 1'b0;
    pc_out_d      = '0;
    sp_load_d     = 1'b0;
    sp_out_d      = '0;
    done_d        = 1'b0;
    busy_d        = (state_d != S_IDLE);

    case (state_d)
      S_PUSH_PC: begin
        mem_req_d   = 1'b1;
        mem_wr_d    = 1'b1;
        mem_addr_d  = W'(sp_d - W'(2));
        mem_wdata_d = pc_d;
      end
      S_PUSH_PSW: begin
        mem_req_d   = 1'b1;
        mem_wr_d    = 1'b1;
        mem_addr_d  = W'(sp_d - W'(4));
        mem_wdata_d = psw_d;
      end
      S_FETCH_VEC: begin
        mem_req_d  = 1'b1;
        mem_addr_d = W'(VECTOR_BASE + {11'd0, vec_d, 1'b0});
      end
      S_POP_PSW: begin
        mem_req_d  = 1'b1;
        mem_addr_d = sp_d;
      end
      S_POP_PC: begin
        mem_req_d  = 1'b1;
        mem_addr_d = W'(sp_d + W'(2));
      end
      S_COMMIT: begin
        psw_wr_en_d   = 2'b11;
        pc_load_d     = 1'b1;
        sp_load_d     = 1'b1;
        done_d        = 1'b1;
        pc_out_d      = pc_d;
        psw_wr_data_d = (mode_d == M_EXC) ? EXC_PSW : psw_d;
        sp_out_d      = (mode_d == M_EXC) ? W'(sp_d - W'(4)) : W'(sp_d + W'(4));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mode_q        <= M_EXC;
      pc_q          <= '0;
      psw_q         <= '0;
      sp_q          <= '0;
      vec_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      psw_wr_en_q   <= 2'b00;
      psw_wr_data_q <= '0;
      pc_load_q     <= 1'b0;
      pc_out_q      <= '0;
      sp_load_q     <= 1'b0;
      sp_out_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      pc_q          <= pc_d;
      psw_q         <= psw_d;
      sp_q          <= sp_d;
      vec_q         <= vec_d;
      mem_req_q     <= mem_req_d;
      mem_wr_q      <= mem_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      psw_wr_en_q   <= psw_wr_en_d;
      psw_wr_data_q <= psw_wr_data_d;
      pc_load_q     <= pc_load_d;
      pc_out_q      <= pc_out_d;
      sp_load_q     <= sp_load_d;
      sp_out_q      <= sp_out_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign psw_wr_en   = psw_wr_en_q;
  assign psw_wr_data = psw_wr_data_q;
  assign pc_load     = pc_load_q;
  assign pc_out      = pc_out_q;
  assign sp_load     = sp_load_q;
  assign sp_out      = sp_out_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_psw_context_unit.sv
// Bench for psw_context_unit: directed and random exception/return transactions against a
// word-array memory model and an expected-access queue built from the context-switch rules.
module tb_psw_context_unit;

  localparam logic [15:0] VB      = 16'hFFC0;
  localparam logic [15:0] EXC_VAL = 16'h0000;

  logic        clk, rst;
  logic [15:0] psw_in, pc_in, sp_in;
  logic        exc_req, reti_req;
  logic [3:0]  exc_vector;
  logic        mem_req, mem_wr, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  psw_wr_en;
  logic [15:0] psw_wr_data, pc_out, sp_out;
  logic        pc_load, sp_load, busy, done;

  psw_context_unit #(.VECTOR_BASE(VB), .EXC_PSW(EXC_VAL)) dut (
    .clk(clk), .rst(rst), .psw_in(psw_in), .pc_in(pc_in), .sp_in(sp_in),
    .exc_req(exc_req), .exc_vector(exc_vector), .reti_req(reti_req),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .psw_wr_en(psw_wr_en), .psw_wr_data(psw_wr_data), .pc_load(pc_load), .pc_out(pc_out),
    .sp_load(sp_load), .sp_out(sp_out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } acc_t;

  logic [15:0] mem [0:32767];
  acc_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          stall_cnt = 0;
  logic [15:0] stall_addr = 16'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected memory traffic and commit values, straight from the entry/return rules
  task automatic run_txn(input bit is_exc, input bit both, input logic [15:0] pc,
                         input logic [15:0] psw, input logic [15:0] sp,
                         input logic [3:0] vec, input int prob);
    logic [15:0] e_psw, e_pc, e_sp, va, a_pc, a_psw;
    acc_t        a;
    int          n_acc, cyc, waits;
    bit          seen, ack;
    exp_q.delete();
    if (is_exc) begin
      a_pc  = sp - 16'd2;
      a_psw = sp - 16'd4;
      va    = VB + 16'(vec) * 16'd2;
      exp_q.push_back('{1'b1, a_pc, pc});
      exp_q.push_back('{1'b1, a_psw, psw});
      if (va == a_psw)     e_pc = psw;
      else if (va == a_pc) e_pc = pc;
      else                 e_pc = mem[va[15:1]];
      exp_q.push_back('{1'b0, va, e_pc});
      e_psw = EXC_VAL;
      e_sp  = sp - 16'd4;
    end else begin
      va    = sp + 16'd2;
      e_psw = mem[sp[15:1]];
      e_pc  = mem[va[15:1]];
      exp_q.push_back('{1'b0, sp, e_psw});
      exp_q.push_back('{1'b0, va, e_pc});
      e_sp  = sp + 16'd4;
    end
    n_acc = exp_q.size();

    check_eq("idle_busy", 32'(busy), 32'd0);
    exc_req    = is_exc;
    reti_req   = !is_exc || both;
    pc_in      = pc;
    psw_in     = psw;
    sp_in      = sp;
    exc_vector = vec;
    mem_ack    = 1'($urandom_range(0, 1));
    @(negedge clk);
    exc_req = 1'b0;
    if (!both) reti_req = 1'b0;
    pc_in  = 16'($urandom);
    psw_in = 16'($urandom);
    sp_in  = 16'($urandom);
    cyc = 1; waits = 0; seen = 0;
    while (cyc < 300 && !seen) begin
      if (done) begin
        check_eq("psw_wr_en", 32'(psw_wr_en), 32'd3);
        check_eq("psw_wr_data", 32'(psw_wr_data), 32'(e_psw));
        check_eq("pc_out", 32'(pc_out), 32'(e_pc));
        check_eq("sp_out", 32'(sp_out), 32'(e_sp));
        check_eq("loads", 32'({pc_load, sp_load}), 32'd3);
        check_eq("commit_no_req", 32'(mem_req), 32'd0);
        check_eq("latency", 32'(cyc), 32'(n_acc + 1 + waits));
        check_eq("acc_left", 32'(exp_q.size()), 32'd0);
        seen = 1;
      end else begin
        check_eq("busy", 32'(busy), 32'd1);
        check_eq("no_commit", 32'({psw_wr_en, pc_load, sp_load}), 32'd0);
        check_eq("mem_req", 32'(mem_req), 32'd1);
        ack = 0;
        if (mem_req) begin
          check_eq("acc_pending", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            a = exp_q[0];
            check_eq("mem_wr", 32'(mem_wr), 32'(a.wr));
            check_eq("mem_addr", 32'(mem_addr), 32'(a.addr));
            if (a.wr) check_eq("mem_wdata", 32'(mem_wdata), 32'(a.data));
            if (stall_cnt > 0 && mem_addr == stall_addr) stall_cnt--;
            else ack = ($urandom_range(0, 99) < prob);
            if (ack) begin
              if (mem_wr) mem[mem_addr[15:1]] = mem_wdata;
              else mem_rdata = mem[mem_addr[15:1]];
              void'(exp_q.pop_front());
            end else waits++;
          end
        end
        mem_ack = ack;
      end
      if (!seen) begin
        @(negedge clk);
        cyc++;
      end
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    reti_req = 1'b0;
    mem_ack  = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_eq("done_pulse", 32'(done), 32'd0);
    check_eq("back_idle", 32'(busy), 32'd0);
    mem_ack = 1'b0;
  endtask

  initial begin
    logic [15:0] r_sp;
    bit          seen;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    rst = 1'b1; exc_req = 1'b0; reti_req = 1'b0; exc_vector = 4'd0;
    psw_in = 16'h0; pc_in = 16'h0; sp_in = 16'h0; mem_ack = 1'b1; mem_rdata = 16'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_outs", 32'({mem_req, mem_wr, psw_wr_en, pc_load, sp_load, busy, done}), 32'd0);
    check_eq("rst_addr", 32'({mem_addr, mem_wdata}), 32'd0);
    check_eq("rst_vals", 32'({pc_out, sp_out}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ack_ignored", 32'({busy, mem_req}), 32'd0);
    mem_ack = 1'b0;

    // Exception entry with back-to-back acks
    mem[16'hFFC6 >> 1] = 16'h4000;
    run_txn(1, 0, 16'h1234, 16'h000B, 16'h0800, 4'd3, 100);
    check_eq("pushed_pc", 32'(mem[16'h07FE >> 1]), 32'h1234);
    check_eq("pushed_psw", 32'(mem[16'h07FC >> 1]), 32'h000B);
    // Return from the frame just built
    run_txn(0, 0, 16'h0, 16'h0, 16'h07FC, 4'd0, 100);
    // Simultaneous requests: exception wins, held reti only acts once back in IDLE
    run_txn(1, 1, 16'hABCD, 16'h5A5A, 16'h1000, 4'd7, 100);
    run_txn(0, 0, 16'h0, 16'h0, 16'h0FFC, 4'd0, 100);
    // Five withheld acks on the PSW push
    stall_cnt = 5; stall_addr = 16'h2000 - 16'd4;
    run_txn(1, 0, 16'h1111, 16'h2222, 16'h2000, 4'd9, 100);
    check_eq("stall_used", 32'(stall_cnt), 32'd0);
    // Stack pointer wrap
    run_txn(1, 0, 16'h3333, 16'h4444, 16'h0002, 4'd15, 100);
    check_eq("wrap_pc", 32'(mem[0]), 32'h3333);
    check_eq("wrap_psw", 32'(mem[16'hFFFE >> 1]), 32'h4444);

    // Reset in FETCH_VEC aborts without any commit
    exc_req = 1'b1; pc_in = 16'h5555; psw_in = 16'h6666; sp_in = 16'h3000; exc_vector = 4'd1;
    @(negedge clk);
    exc_req = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (mem_req && !mem_wr) begin
        seen = 1;
        rst = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 16'hBEEF;
      end else begin
        mem_ack = mem_req;
        if (mem_req && mem_wr) mem[mem_addr[15:1]] = mem_wdata;
      end
      @(negedge clk);
    end
    check_eq("rst_fetch_seen", 32'(seen), 32'd1);
    check_eq("rst_mid_req", 32'(mem_req), 32'd0);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_upd", 32'({psw_wr_en, pc_load, sp_load, done}), 32'd0);
    rst = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_idle", 32'({busy, done}), 32'd0);

    // Random mix of entries and returns with random wait states
    for (int t = 0; t < 40; t++) begin
      r_sp = 16'($urandom) & 16'hFFFE;
      if ($urandom_range(0, 1) == 1)
        run_txn(1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), r_sp,
                4'($urandom), int'($urandom_range(30, 100)));
      else
        run_txn(0, 0, 16'h0, 16'h0, r_sp, 4'd0, int'($urandom_range(30, 100)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
